byte_receiver: RTL and testbench

- USB full-speed receive byte path; mirror of the transmit byte path (parallel-to-serial register, bit timer, bit stuffer, NRZI encoder).
- Takes raw d_plus/d_minus, oversampled at 8 clocks per bit. Performs line sync, NRZI decode, SYNC detection, bit unstuffing and byte assembly.
- Flags EOP and errors toward the receive FSM/FIFO.

---
 rtl/usb_rx_pkg.sv | 17 +
 rtl/rx_bit_sampler.sv | 61 ++++++
 rtl/byte_receiver.sv | 190 +++++++++++++++++++
 tb/tb_byte_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive byte path.
// The optional CRC16 check in byte_receiver is enabled by defining RX_CRC16_EN.
package usb_rx_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, RECEIVE, EOP, ERROR} rx_state_t;

  localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
  localparam int          STUFF_LIMIT    = 6;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // One serial CRC16 step, data bit presented in arrival order.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Line synchronizers, edge-aligned bit timer and NRZI decode for the USB receive path.
// Produces a one-cycle sample strobe together with the decoded bit and line states.
module rx_bit_sampler
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic idle,
  output logic strobe,
  output logic nrzi_bit,
  output logic se0,
  output logic j,
  output logic k_fall
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  logic          dp_meta, dp_s, dp_d;
  logic          dm_meta, dm_s;
  logic [TW-1:0] timer;
  logic          prev_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_meta    <= 1'b1;
      dp_s       <= 1'b1;
      dp_d       <= 1'b1;
      dm_meta    <= 1'b0;
      dm_s       <= 1'b0;
      timer      <= '0;
      prev_level <= 1'b1;
    end else begin
      dp_meta <= d_plus;
      dp_s    <= dp_meta;
      dp_d    <= dp_s;
      dm_meta <= d_minus;
      dm_s    <= dm_meta;
      // Re-align the bit timer to every D+ edge so sampling tracks the sender.
      if (dp_s != dp_d || timer == TW'(CLKS_PER_BIT - 1))
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (idle)
        prev_level <= 1'b1;
      else if (strobe)
        prev_level <= dp_s;
    end
  end

  assign strobe   = (timer == TW'(SAMPLE_POINT));
  assign nrzi_bit = (dp_s == prev_level);
  assign se0      = !dp_s && !dm_s;
  assign j        = dp_s && !dm_s;
  assign k_fall   = dp_d && !dp_s && dm_s;

endmodule

// File: rtl/byte_receiver.sv
// USB full-speed receive byte path: SYNC detect, bit unstuffing, byte assembly and EOP.
// Optional CRC16 residual check is compiled in when RX_CRC16_EN is defined.
//
// state   | meaning
// IDLE    | line idle (J), waiting for J->K edge
// SYNC    | collecting 8 SYNC bits, expect 8'h80
// RECEIVE | assembling data bytes, unstuffing
// EOP     | first SE0 seen, waiting for SE0 then J
// ERROR   | packet aborted, waiting for SE0 then J
module byte_receiver
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic [7:0] byte_count,
  output logic       rx_active,
  output logic       eop_detected,
  output logic       rx_error,
  output logic       crc_error
);

  rx_state_t  state;
  logic [7:0] shift;
  logic [7:0] shift_next;
  logic [2:0] bit_idx;
  logic [2:0] ones_cnt;
  logic       eop_se0_seen;
  logic       err_se0_seen;
  logic       strobe, nrzi_bit, se0, j, k_fall;
  logic       stuff_due;
  logic       pkt_start;

  rx_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_POINT(SAMPLE_POINT)
  ) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .d_plus  (d_plus),
    .d_minus (d_minus),
    .idle    (state == IDLE),
    .strobe  (strobe),
    .nrzi_bit(nrzi_bit),
    .se0     (se0),
    .j       (j),
    .k_fall  (k_fall)
  );

  assign shift_next = {nrzi_bit, shift[7:1]};
  assign stuff_due  = (ones_cnt == 3'(STUFF_LIMIT));
  assign pkt_start  = (state == IDLE) && k_fall;
  assign rx_active  = (state == SYNC) || (state == RECEIVE) || (state == EOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shift        <= '0;
      bit_idx      <= '0;
      ones_cnt     <= '0;
      eop_se0_seen <= 1'b0;
      err_se0_seen <= 1'b0;
      rx_byte      <= '0;
      byte_valid   <= 1'b0;
      byte_count   <= '0;
      eop_detected <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      byte_valid   <= 1'b0;
      eop_detected <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_start) begin
            state      <= SYNC;
            rx_error   <= 1'b0;
            byte_count <= '0;
            bit_idx    <= '0;
            ones_cnt   <= '0;
            shift      <= '0;
          end
        end
        SYNC, RECEIVE: begin
          if (strobe) begin
            if (se0) begin
              if (state == SYNC || bit_idx != 3'd0) rx_error <= 1'b1;
              state        <= (state == SYNC) ? ERROR : EOP;
              eop_se0_seen <= 1'b0;
              err_se0_seen <= 1'b1;
            end else if (stuff_due) begin
              if (nrzi_bit) begin
                rx_error     <= 1'b1;
                state        <= ERROR;
                err_se0_seen <= 1'b0;
              end else begin
                ones_cnt <= '0;
              end
            end else begin
              ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
              shift    <= shift_next;
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                if (state == SYNC) begin
                  if (shift_next == SYNC_PATTERN) begin
                    state <= RECEIVE;
                  end else begin
                    rx_error     <= 1'b1;
                    state        <= ERROR;
                    err_se0_seen <= 1'b0;
                  end
                end else if (byte_count == 8'(MAX_BYTES)) begin
                  // Overflow takes priority over delivering the byte.
                  rx_error     <= 1'b1;
                  state        <= ERROR;
                  err_se0_seen <= 1'b0;
                end else begin
                  rx_byte    <= shift_next;
                  byte_valid <= 1'b1;
                  byte_count <= byte_count + 8'd1;
                end
              end
            end
          end
        end
        EOP: begin
          if (strobe) begin
            if (se0 && !eop_se0_seen) begin
              eop_se0_seen <= 1'b1;
            end else if (j) begin
              state        <= IDLE;
              eop_detected <= 1'b1;
            end else begin
              state        <= ERROR;
              err_se0_seen <= se0;
            end
          end
        end
        ERROR: begin
          if (strobe) begin
            if (se0)
              err_se0_seen <= 1'b1;
            else if (j && err_se0_seen)
              state <= IDLE;
            else
              err_se0_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_CRC16_EN
  logic [15:0] crc;
  logic        crc_flag;
  logic        take_bit;
  logic        eop_ok;

  // CRC covers every accepted data bit after the PID byte, including the CRC field.
  assign take_bit = strobe && (state == RECEIVE) && !se0 && !stuff_due;
  assign eop_ok   = strobe && (state == EOP) && j;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc      <= 16'hFFFF;
      crc_flag <= 1'b0;
    end else begin
      if (pkt_start) begin
        crc      <= 16'hFFFF;
        crc_flag <= 1'b0;
      end else if (take_bit && byte_count != 8'd0) begin
        crc <= crc16_step(crc, nrzi_bit);
      end
      if (eop_ok && byte_count >= 8'd3 && crc != CRC16_RESIDUAL)
        crc_flag <= 1'b1;
    end
  end

  assign crc_error = crc_flag;
`else
  assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_byte_receiver.sv
// Self-checking bench for byte_receiver: directed and random packets encoded by a
// behavioural USB transmitter model, expectations derived from packet contents.
module tb_byte_receiver;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [7:0] byte_count;
  logic       rx_active;
  logic       eop_detected;
  logic       rx_error;
  logic       crc_error;

  byte_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .d_plus      (d_plus),
    .d_minus     (d_minus),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .byte_count  (byte_count),
    .rx_active   (rx_active),
    .eop_detected(eop_detected),
    .rx_error    (rx_error),
    .crc_error   (crc_error)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] got[$];
  logic [7:0] pkt[$];
  int         eop_n = 0;
  logic       crc_at_eop = 1'b0;
  bit         level = 1'b1;
  int         ones = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) got.push_back(rx_byte);
      if (eop_detected) begin
        eop_n++;
        crc_at_eop = crc_error;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic dp, input logic dm, input int bits);
    d_plus  = dp;
    d_minus = dm;
    repeat (bits * 8) @(negedge clk);
  endtask

  task automatic nrzi(input bit b);
    if (!b) level = ~level;
    hold(level, ~level, 1);
  endtask

  task automatic tx(input bit b, input bit stuff_en);
    nrzi(b);
    ones = b ? ones + 1 : 0;
    if (stuff_en && ones == 6) begin
      nrzi(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_sync(input logic [7:0] s);
    level = 1'b1;
    ones  = 0;
    for (int i = 0; i < 8; i++) tx(s[i], 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stuff_en);
    for (int i = 0; i < 8; i++) tx(b[i], stuff_en);
  endtask

  task automatic send_eop();
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 1);
    level = 1'b1;
    hold(1'b1, 1'b0, 4);
  endtask

  // CRC16 field a compliant transmitter appends after bytes 1..last; [15:8] is sent first.
  function automatic logic [15:0] crc_trailer(input logic [7:0] q[$], input int last);
    logic [15:0] c;
    logic [15:0] t;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int b = 1; b <= last; b++)
      for (int i = 0; i < 8; i++) begin
        fb = q[b][i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    t = ~c;
    for (int i = 0; i < 8; i++) begin
      r[8 + i] = t[15 - i];
      r[i]     = t[7 - i];
    end
    return r;
  endfunction

  function automatic bit crc_bad_model(input logic [7:0] q[$]);
`ifdef RX_CRC16_EN
    logic [15:0] tr;
    int          n;
    n = q.size();
    if (n < 3 || n > 64) return 1'b0;
    tr = crc_trailer(q, n - 3);
    return !(q[n - 2] == tr[15:8] && q[n - 1] == tr[7:0]);
`else
    return (q.size() < 0);
`endif
  endfunction

  task automatic run_pkt(input string tag);
    int n, nv;
    bit exp_err, exp_crc;
    got.delete();
    eop_n = 0;
    send_sync(SYNC_PATTERN);
    foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    send_eop();
    n       = pkt.size();
    nv      = (n > 64) ? 64 : n;
    exp_err = (n > 64);
    exp_crc = crc_bad_model(pkt);
    chk({tag, "_nbytes"}, got.size(), nv);
    for (int i = 0; i < got.size() && i < nv; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(pkt[i]));
    chk({tag, "_count"}, 32'(byte_count), nv);
    chk({tag, "_eop"}, eop_n, exp_err ? 0 : 1);
    chk({tag, "_err"}, 32'(rx_error), 32'(exp_err));
    chk({tag, "_crc"}, 32'(crc_error), 32'(exp_crc));
    if (eop_n == 1) chk({tag, "_crc_at_eop"}, 32'(crc_at_eop), 32'(exp_crc));
  endtask

  initial begin
    logic [15:0] tr;
    int          n;

    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({rx_byte, byte_valid, byte_count, rx_active, eop_detected,
                           rx_error, crc_error}), 0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    hold(1'b1, 1'b0, 4);

    pkt = '{8'hA5, 8'h3C};
    run_pkt("a5_3c");

    pkt = '{8'hFF};
    run_pkt("stuffed_ff");

    // Seven ones in a row: transmitter omits the stuff bit.
    got.delete();
    eop_n = 0;
    send_sync(SYNC_PATTERN);
    send_byte(8'hFF, 1'b0);
    chk("seven_ones_err", 32'(rx_error), 1);
    chk("seven_ones_active", 32'(rx_active), 0);
    send_eop();
    chk("seven_ones_eop", eop_n, 0);
    chk("seven_ones_nbytes", got.size(), 0);
    chk("seven_ones_state", 32'(dut.state), 32'(IDLE));

    got.delete();
    eop_n = 0;
    send_sync(8'h82);
    send_byte(8'h11, 1'b1);
    send_eop();
    chk("bad_sync_err", 32'(rx_error), 1);
    chk("bad_sync_nbytes", got.size(), 0);
    chk("bad_sync_eop", eop_n, 0);
    pkt = '{8'h5A, 8'h0F, 8'hF0};
    run_pkt("after_bad_sync");

    // Reset 12 data bits into a packet, with the line parked at J first.
    send_sync(SYNC_PATTERN);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) tx(1'(8'h3C >> i), 1'b1);
    hold(1'b1, 1'b0, 1);
    level = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", 32'({rx_byte, byte_valid, byte_count, rx_active, eop_detected,
                            rx_error, crc_error}), 0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    hold(1'b1, 1'b0, 4);
    pkt = '{8'h96, 8'h69};
    run_pkt("after_rst");

    for (int k = 0; k < 6; k++) begin
      pkt.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run_pkt($sformatf("rand%0d", k));
    end

    pkt.delete();
    for (int i = 0; i < 65; i++) pkt.push_back(8'($urandom));
    run_pkt("overflow");

    pkt = '{8'hC3, 8'h00, 8'h01};
    tr  = crc_trailer(pkt, 2);
    pkt.push_back(tr[15:8]);
    pkt.push_back(tr[7:0]);
    run_pkt("crc_good");
    pkt[1] = 8'h04;
    run_pkt("crc_flip");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
